// File: rtl/bicubic_tap_acc_if.sv
// Handshake bundle between bicubic_tap_acc and its neighbours: the start/in_ready request
// from upstream, the tap select/value pair shared with the 4:1 tap mux, and the
// out_valid/out_ready/out_pix result channel to the next interpolation stage.
// The master side is the surrounding environment; the slave side is the accumulator.
interface bicubic_tap_acc_if #(
    parameter int unsigned DATA_W = 15,
    parameter int unsigned PIX_W  = 8
);
    logic                     start;
    logic                     in_ready;
    logic signed [DATA_W-1:0] tap_in;
    logic [1:0]               mux_sel;
    logic                     out_valid;
    logic                     out_ready;
    logic [PIX_W-1:0]         out_pix;

    modport master (
        output start,
        input  in_ready,
        output tap_in,
        input  mux_sel,
        input  out_valid,
        output out_ready,
        input  out_pix
    );

    modport slave (
        input  start,
        output in_ready,
        input  tap_in,
        output mux_sel,
        output out_valid,
        input  out_ready,
        output out_pix
    );
endinterface

// File: rtl/bicubic_tap_acc.sv
// Bicubic tap sequencer/accumulator. Walks the tap mux select through taps 0..3, sums the
// four signed weighted taps, scales the sum to integer by an arithmetic right shift of
// FRAC_W and clamps it to an unsigned PIX_W-bit pixel held behind a valid/ready handshake.
// Optional feature: define TAP_ACC_ROUND_EN to add 2^(FRAC_W-1) before the shift
// (round half up); left undefined the shift floors and no rounding adder exists.
module bicubic_tap_acc #(
    parameter int unsigned DATA_W = 15,
    parameter int unsigned FRAC_W = 6,
    parameter int unsigned PIX_W  = 8
) (
    input logic              clk,
    input logic              rst_n,
    bicubic_tap_acc_if.slave bus
);

    // Four taps of DATA_W bits need two guard bits; one more absorbs the rounding offset.
    localparam int unsigned ACC_W   = DATA_W + 2;
    localparam int unsigned SCALE_W = DATA_W + 3;

    localparam logic signed [SCALE_W-1:0] PIX_MAX = SCALE_W'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } state_e;

    state_e                    r_state;
    state_e                    w_state_next;
    logic [1:0]                r_cnt;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_out_valid;
    logic [PIX_W-1:0]          r_out_pix;

    logic signed [ACC_W-1:0]   w_sum_next;
    logic signed [SCALE_W-1:0] w_scale_in;
    logic signed [SCALE_W-1:0] w_shifted;
    logic [PIX_W-1:0]          w_pix;
    logic                      w_last_tap;

    // Running sum including the tap currently presented by the mux.
    assign w_sum_next = r_acc + $signed({{2{bus.tap_in[DATA_W-1]}}, bus.tap_in});
    assign w_last_tap = (r_cnt == 2'd3);

`ifdef TAP_ACC_ROUND_EN
    localparam logic signed [SCALE_W-1:0] ROUND_OFS = SCALE_W'(1 << (FRAC_W - 1));

    // Round half up: bias by half an LSB of the integer result before flooring.
    assign w_scale_in = $signed({w_sum_next[ACC_W-1], w_sum_next}) + ROUND_OFS;
`else
    // Plain floor: sign-extend only, no rounding adder.
    assign w_scale_in = $signed({w_sum_next[ACC_W-1], w_sum_next});
`endif

    assign w_shifted = w_scale_in >>> FRAC_W;

    // Saturate the scaled sum into the unsigned pixel range.
    always_comb begin
        w_pix = w_shifted[PIX_W-1:0];
        if (w_shifted[SCALE_W-1]) begin
            w_pix = '0;
        end else if (w_shifted > PIX_MAX) begin
            w_pix = PIX_MAX[PIX_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured where in_ready is high.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_next = StAcc;
                end
            end
            StAcc: begin
                if (w_last_tap) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_next = bus.start ? StAcc : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from registered state; mux_sel only moves on clock edges.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.mux_sel   = 2'd0;
        bus.out_valid = r_out_valid;
        bus.out_pix   = r_out_pix;
        unique case (r_state)
            StIdle:  bus.in_ready = 1'b1;
            StAcc:   bus.mux_sel  = r_cnt;
            StDone:  bus.in_ready = bus.out_ready;
            default: bus.in_ready = 1'b0;
        endcase
    end

    // Tap counter, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 2'd0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_cnt <= 2'd0;
                        r_acc <= '0;
                    end
                end
                StAcc: begin
                    if (w_last_tap) begin
                        r_out_pix   <= w_pix;
                        r_out_valid <= 1'b1;
                        r_cnt       <= 2'd0;
                    end else begin
                        r_acc <= w_sum_next;
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                StDone: begin
                    // Clearing acc here makes the back-to-back restart start from zero.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= 2'd0;
                    end
                end
                default: begin
                    r_cnt       <= 2'd0;
                    r_acc       <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bicubic_tap_acc.md
# bicubic_tap_acc

Tap sequencer and accumulator that sits directly downstream of the 4:1 15-bit tap multiplexer in the bicubic datapath. It drives the mux select through taps 0..3, sums the four signed weighted-tap values it returns, and scales the result to fixed point. It then clamps it to an 8-bit pixel and presents it with a valid/ready handshake to the next interpolation stage.

## Interface
Parameters:
- DATA_W, 15, width of each signed two's-complement weighted tap from the mux
- FRAC_W, 6, fractional bits in the weighted tap (result is shifted right by this)
- PIX_W, 8, output pixel width (unsigned)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to accumulate one pixel; accepted only when in_ready=1
- in_ready  output  1  block can accept start this cycle
- tap_in  input  DATA_W  signed tap value returned combinationally by the mux for the current mux_sel
- mux_sel  output  2  tap select driven to the mux
- out_valid  output  1  out_pix holds a finished pixel
- out_ready  input  1  downstream accepts out_pix
- out_pix  output  PIX_W  clamped, scaled pixel result

## Operation
- States: IDLE, ACC, DONE; 2-bit tap counter cnt; signed accumulator acc of DATA_W+2 bits.
- IDLE: in_ready=1, mux_sel=0, out_valid=0. start=1 -> ACC, cnt=0, acc=0.
- ACC: mux_sel=cnt (registered), in_ready=0. Each cycle sum_next = acc + sign_ext(tap_in).
  - cnt<3: acc<=sum_next, cnt<=cnt+1.
  - cnt==3: out_pix<=clamp(scale(sum_next)), out_valid<=1, go DONE, cnt<=0.
- DONE: mux_sel=0, out_valid=1, out_pix stable. in_ready=out_ready.
  - out_ready=1 and start=0 -> IDLE, out_valid<=0.
  - out_ready=1 and start=1 -> ACC directly (back-to-back), acc=0, cnt=0, out_valid<=0.
  - out_ready=0: hold everything, and ignore start.
- start in ACC is ignored (no queuing).
- scale(): compute in DATA_W+3 bits (no overflow with the rounding offset). Arithmetic shift right by FRAC_W, with optional rounding (see Configuration).
- clamp(): result <0 -> 0; result >2^PIX_W-1 -> 2^PIX_W-1; otherwise the low PIX_W bits.
- Reset (any time, including mid-ACC or in DONE): state=IDLE, cnt=0, acc=0, mux_sel=0, out_valid=0, out_pix=0, in_ready=1 after release. Any partial sum is discarded.

## Timing
- Start accepted at edge k. Taps 0..3 are sampled at edges k+1..k+4, and out_valid is high after edge k+4 (latency 4 cycles).
- mux_sel changes only on clock edges. tap_in must be settled within the same cycle, since the mux is purely combinational.
- Peak throughput: one pixel per 5 cycles (4 ACC + 1 DONE with out_ready=1 and start=1).
- out_pix and out_valid are registered outputs. They do not change while out_valid=1 and out_ready=0.

## Configuration
- TAP_ACC_ROUND_EN defined: scale adds 2^(FRAC_W-1) before the arithmetic shift (round half up).
- TAP_ACC_ROUND_EN undefined: plain arithmetic shift (floor); no rounding adder is synthesized.

## Test plan
- Taps 1000, 2000, 3000, 4000, out_ready=1 -> mux_sel sequence 0,1,2,3; out_valid 4 cycles after start; out_pix=156 (sum 10000/64).
- Taps 96, 0, 0, 0 -> out_pix=2 with TAP_ACC_ROUND_EN, 1 without.
- Taps -5000, 100, 100, 100 (sum -4700) -> out_pix=0. Taps 16383 ×4 (sum 65532) -> out_pix=255; no wrap, with or without rounding.
- out_ready held low 10 cycles after a result: out_valid=1, out_pix unchanged, mux_sel=0, in_ready=0, start pulses ignored. Then out_ready=1 with start=1 -> next pixel accumulates immediately, with mux_sel=0 in the following cycle.
- rst_n pulled low when cnt=2 -> mux_sel=0, out_valid=0, out_pix=0 asynchronously. After release, a start with taps 64 ×4 gives out_pix=4 (no residue from the aborted sum).
